aes_load_ctrl: RTL and testbench

- Byte-serial load sequencer and arbiter in front of the shared 16-byte deserializer register of the AES256 core.
- Two requesters share the deserializer: a key stream (32-byte AES256 key, delivered as two 16-byte halves) and a plaintext stream (16-byte blocks).
- The block arbitrates at block granularity, drives the register's write enable and byte, and presents each full 16-byte block to the core with a valid/ack handshake.

---
 rtl/aes_load_ctrl.sv | 107 ++++++++++
 tb/tb_aes_load_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_load_ctrl.sv
// aes_load_ctrl: byte-serial load sequencer and block-granular arbiter for the shared AES256 deserializer
module aes_load_ctrl #(
    parameter int BLK_BYTES = 16,
    parameter int KEY_BLKS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       key_ready,
    input  logic       pt_valid,
    input  logic [7:0] pt_byte,
    output logic       pt_ready,
    output logic       reg_wr_en,
    output logic [7:0] reg_byte,
    output logic       blk_valid,
    output logic       blk_is_key,
    output logic       key_half,
    input  logic       blk_ack,
    output logic       key_loaded,
    output logic       busy
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD_KEY = 2'd1;
    localparam logic [1:0] LOAD_PT  = 2'd2;
    localparam logic [1:0] WAIT_ACK = 2'd3;
    localparam logic [3:0] LAST_BYTE = 4'(BLK_BYTES - 1);
    localparam logic       LAST_HALF = 1'(KEY_BLKS - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       key_half_q, key_half_d;
    logic       key_loaded_q, key_loaded_d;
    logic       is_key_q, is_key_d;
    logic       xfer;

    assign key_ready  = state_q == LOAD_KEY;
    assign pt_ready   = state_q == LOAD_PT;
    assign xfer       = (key_ready & key_valid) | (pt_ready & pt_valid);
    assign reg_wr_en  = xfer;
    assign reg_byte   = key_ready ? key_byte : pt_byte;
    assign blk_valid  = state_q == WAIT_ACK;
    assign blk_is_key = is_key_q;
    assign key_half   = key_half_q;
    assign key_loaded = key_loaded_q;
    assign busy       = state_q != IDLE;

    // Grant in IDLE (key first), count 16 writes, then hold the block until the core acks it
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_half_d   = key_half_q;
        key_loaded_d = key_loaded_q;
        is_key_d     = is_key_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d      = LOAD_KEY;
                    key_loaded_d = 1'b0;
                    key_half_d   = 1'b0;
                    is_key_d     = 1'b1;
                end else if (pt_valid && key_loaded_q) begin
                    state_d  = LOAD_PT;
                    is_key_d = 1'b0;
                end
            end
            LOAD_KEY, LOAD_PT: begin
                if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_BYTE) state_d = WAIT_ACK;
                end
            end
            default: begin
                if (blk_ack) begin
                    if (!is_key_q) begin
                        state_d = IDLE;
                    end else if (key_half_q != LAST_HALF) begin
                        key_half_d = key_half_q + 1'b1;
                        state_d    = LOAD_KEY;
                    end else begin
                        key_loaded_d = 1'b1;
                        key_half_d   = 1'b0;
                        is_key_d     = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
        endcase
    end

    // State registers; reset discards any partial block together with the deserializer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            key_half_q   <= 1'b0;
            key_loaded_q <= 1'b0;
            is_key_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_half_q   <= key_half_d;
            key_loaded_q <= key_loaded_d;
            is_key_q     <= is_key_d;
        end
    end
endmodule

// File: tb/tb_aes_load_ctrl.sv
// tb_aes_load_ctrl: scoreboard bench for aes_load_ctrl with directed scenarios and a random phase
module tb_aes_load_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0, pt_valid = 1'b0, blk_ack = 1'b0;
    logic [7:0] key_byte = 8'd0, pt_byte = 8'd0;
    logic       key_ready, pt_ready, reg_wr_en, blk_valid, blk_is_key, key_half, key_loaded, busy;
    logic [7:0] reg_byte;
    logic [7:0] outs;

    typedef struct packed {
        logic [127:0] d;
        logic         k;
        logic         h;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [127:0] sh = '0;
    logic         prev_bv = 1'b0;
    int           widx = 0, run = 0, last_run = 0, cyc = 0, prev_rise = 0, last_rise = 0;
    int           ack_mode = 1;
    int           n_cmp = 0, n_bad = 0;

    assign outs = {key_ready, pt_ready, reg_wr_en, blk_valid, blk_is_key, key_half, key_loaded, busy};

    always #5 clk = ~clk;

    aes_load_ctrl dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_byte(key_byte), .key_ready(key_ready),
        .pt_valid(pt_valid), .pt_byte(pt_byte), .pt_ready(pt_ready),
        .reg_wr_en(reg_wr_en), .reg_byte(reg_byte),
        .blk_valid(blk_valid), .blk_is_key(blk_is_key), .key_half(key_half),
        .blk_ack(blk_ack), .key_loaded(key_loaded), .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] r128();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // ack driver: 0 = held low, 1 = tied high, 2 = random
    initial forever begin
        @(posedge clk);
        #1;
        blk_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : (ack_mode == 1);
    end

    // Monitor: shadows the deserializer from the write strobe and checks each presented block
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            widx = 0;
            run = 0;
            prev_bv = 1'b0;
        end else begin
            if (reg_wr_en) begin
                if (widx < 16) sh[widx*8 +: 8] = reg_byte;
                widx++;
                run++;
            end else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (blk_valid && !prev_bv) begin
                prev_rise = last_rise;
                last_rise = cyc;
                chk("blk_len", 128'(widx), 128'(16));
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL blk_unexpected: got block %h with none expected", sh);
                end else begin
                    mon_e = sb.pop_front();
                    chk("blk_data", sh, mon_e.d);
                    chk("blk_flags", 128'({blk_is_key, key_half}), 128'({mon_e.k, mon_e.h}));
                end
                widx = 0;
            end
            prev_bv = blk_valid;
        end
    end

    task automatic push_byte(input bit kf, input logic [7:0] b, input int gap);
        int t;
        bit ok;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        if (kf) begin
            key_valid = 1'b1;
            key_byte = b;
        end else begin
            pt_valid = 1'b1;
            pt_byte = b;
        end
        t = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = kf ? key_ready : pt_ready;
            @(posedge clk);
            #1;
            t++;
            if (!ok && t > 3000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: byte %h (key=%0d) not accepted within 3000 cycles", b, kf);
                ok = 1'b1;
            end
        end
        if (kf) key_valid = 1'b0;
        else pt_valid = 1'b0;
    endtask

    task automatic send_key(input logic [255:0] kv, input int gmax, input bit psh);
        if (psh) begin
            sb.push_back(exp_t'{d: kv[127:0], k: 1'b1, h: 1'b0});
            sb.push_back(exp_t'{d: kv[255:128], k: 1'b1, h: 1'b1});
        end
        for (int i = 0; i < 32; i++) push_byte(1'b1, kv[i*8 +: 8], $urandom_range(0, gmax));
    endtask

    task automatic send_pt(input logic [127:0] pv, input int gmax, input bit psh);
        if (psh) sb.push_back(exp_t'{d: pv, k: 1'b0, h: 1'b0});
        for (int i = 0; i < 16; i++) push_byte(1'b0, pv[i*8 +: 8], $urandom_range(0, gmax));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 128'({sb.size() != 0, busy}), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] kv;
        logic [127:0] pv;
        int bad;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", 128'(outs), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("idle_after_reset", 128'(outs), 128'(0));

        // plaintext offered with no key loaded is never granted
        pt_valid = 1'b1;
        pt_byte = 8'h55;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (pt_ready || reg_wr_en || busy) bad++;
        end
        chk("pt_blocked_no_key", 128'(bad), 128'(0));
        @(posedge clk);
        #1;
        pt_valid = 1'b0;

        // key 0x00..0x1F, then key_loaded one cycle after the second ack
        for (int i = 0; i < 32; i++) kv[i*8 +: 8] = 8'(i);
        send_key(kv, 0, 1'b1);
        @(negedge clk);
        chk("key_wait", 128'({blk_valid, key_loaded, key_half}), 128'(3'b101));
        @(negedge clk);
        chk("key_loaded", 128'({blk_valid, key_loaded, busy, key_half}), 128'(4'b0100));
        #1;
        chk("wr_run", 128'(last_run), 128'(16));
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) pv[i*8 +: 8] = 8'(8'hA0 + i);
        send_pt(pv, 0, 1'b1);

        // back-to-back plaintext blocks at minimum period
        send_pt(r128(), 0, 1'b1);
        send_pt(r128(), 0, 1'b1);
        @(negedge clk);
        #1;
        chk("pt_period", 128'(last_rise - prev_rise), 128'(18));
        @(posedge clk);
        #1;
        drain();

        // ack held low: block stays presented and a new key waits
        ack_mode = 0;
        send_pt(r128(), 0, 1'b1);
        fork
            send_key({r128(), r128()}, 0, 1'b1);
            begin
                int hb;
                hb = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (!blk_valid || key_ready || pt_ready || reg_wr_en) hb++;
                end
                chk("ack_hold", 128'(hb), 128'(0));
                ack_mode = 1;
            end
        join
        drain();

        // key and plaintext together in IDLE: key wins and clears key_loaded
        chk("pre_contention_loaded", 128'(key_loaded), 128'(1));
        kv = {r128(), r128()};
        pv = r128();
        sb.push_back(exp_t'{d: kv[127:0], k: 1'b1, h: 1'b0});
        sb.push_back(exp_t'{d: kv[255:128], k: 1'b1, h: 1'b1});
        sb.push_back(exp_t'{d: pv, k: 1'b0, h: 1'b0});
        fork
            send_key(kv, 0, 1'b0);
            send_pt(pv, 0, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("contention_grant", 128'({key_ready, pt_ready, key_loaded}), 128'(3'b100));
            end
        join
        drain();

        // asynchronous reset after the 7th plaintext byte
        for (int i = 0; i < 7; i++) push_byte(1'b0, 8'($urandom()), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", 128'(outs), 128'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_key({r128(), r128()}, 1, 1'b1);
        send_pt(r128(), 1, 1'b1);
        drain();

        // key_valid toggling during a plaintext load is ignored
        fork
            send_pt(r128(), 0, 1'b1);
            begin
                int t, w, kb;
                t = 0;
                w = 0;
                kb = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!pt_ready && t < 100);
                while (!blk_valid && t < 300) begin
                    if (reg_wr_en) w++;
                    if (key_ready) kb++;
                    key_valid = ~key_valid;
                    @(negedge clk);
                    t++;
                end
                key_valid = 1'b0;
                chk("toggle_writes", 128'(w), 128'(16));
                chk("toggle_key_ready", 128'(kb), 128'(0));
            end
        join
        drain();

        // random traffic with random gaps and random ack delay
        ack_mode = 2;
        repeat (30) begin
            if ($urandom_range(0, 3) == 0) send_key({r128(), r128()}, 2, 1'b1);
            else send_pt(r128(), 2, 1'b1);
        end
        drain();
        chk("final_key_loaded", 128'(key_loaded), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
